// File: rtl/dbg_ctrl.sv
// Debug/run controller: gates the core with run/halt/step/breakpoint
// and arbitrates debug access to imem, dmem and regfile while halted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     host command handshake
//   cmd_op/addr/data    command opcode, word address, payload
//   rsp_valid/err/data  one-cycle response strobe, error flag, payload
//   cpu_en              core advance enable
//   cpu_pc, cpu_stop    core fetch PC, halt-instruction flag
//   inst_*, data_*      debug imem/dmem write strobe, address, data, read data
//   rf_dcp_rd, rf_addr  regfile debug read select and index, rf_out read data
//   halted, halt_cause  not-running flag, reason for last halt
module dbg_ctrl #(
  parameter int BP_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_data,
  output logic        cpu_en,
  input  logic [31:0] cpu_pc,
  input  logic        cpu_stop,
  output logic        inst_we,
  output logic        data_we,
  output logic [7:0]  inst_addr,
  output logic [7:0]  data_addr,
  output logic [31:0] inst_in,
  output logic [31:0] data_in,
  output logic        rf_dcp_rd,
  output logic [4:0]  rf_addr,
  input  logic [31:0] inst_out,
  input  logic [31:0] data_out,
  input  logic [31:0] rf_out,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  typedef enum logic [2:0] {
    S_HALT, S_RUN, S_STEP, S_ACC, S_RESP
  } state_e;

  localparam logic [3:0] OP_STATUS = 4'd0;
  localparam logic [3:0] OP_RUN    = 4'd1;
  localparam logic [3:0] OP_STEP   = 4'd2;
  localparam logic [3:0] OP_HALT   = 4'd3;
  localparam logic [3:0] OP_SETBP  = 4'd4;
  localparam logic [3:0] OP_CLRBP  = 4'd5;
  localparam logic [3:0] OP_WINST  = 4'd6;
  localparam logic [3:0] OP_WDATA  = 4'd7;
  localparam logic [3:0] OP_RINST  = 4'd8;
  localparam logic [3:0] OP_RDATA  = 4'd9;
  localparam logic [3:0] OP_RREG   = 4'd10;
  localparam logic [3:0] OP_CYCLES = 4'd11;

  localparam logic [1:0] C_CMD  = 2'd1;
  localparam logic [1:0] C_BP   = 2'd2;
  localparam logic [1:0] C_STOP = 2'd3;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [BP_W-1:0]   bp_q, bp_d;
  logic              bp_en_q, bp_en_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_pc_q, rsp_pc_d;
  logic [7:0]        iaddr_q, iaddr_d;
  logic [7:0]        daddr_q, daddr_d;
  logic [31:0]       idata_q, idata_d;
  logic [31:0]       ddata_q, ddata_d;
  logic [4:0]        raddr_q, raddr_d;

  logic accept;
  logic bp_hit;

  assign cmd_ready = (state_q == S_HALT) || (state_q == S_RUN);
  assign accept    = cmd_valid && cmd_ready;
  assign bp_hit    = bp_en_q && (cpu_pc[BP_W-1:0] == bp_q);

  // Combinational gate so the breakpoint instruction is never
  // advanced past; STEP ignores the breakpoint on purpose.
  always_comb begin
    cpu_en = 1'b0;
    if (state_q == S_RUN) begin
      cpu_en = !bp_hit && !cpu_stop;
    end else if (state_q == S_STEP) begin
      cpu_en = 1'b1;
    end
  end

  assign cnt_d = cnt_q + {31'd0, cpu_en};

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bp_d        = bp_q;
    bp_en_d     = bp_en_q;
    cause_d     = cause_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_pc_d    = 1'b0;
    iaddr_d     = iaddr_q;
    daddr_d     = daddr_q;
    idata_d     = idata_q;
    ddata_d     = ddata_q;
    raddr_d     = raddr_q;
    case (state_q)
      S_HALT: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          state_d     = S_RESP;
          case (cmd_op)
            OP_STATUS: rsp_data_d = cpu_pc;
            OP_CYCLES: rsp_data_d = cnt_q;
            OP_HALT:   ;
            OP_RUN:    state_d = S_RUN;
            OP_SETBP: begin
              bp_d    = cmd_data[BP_W-1:0];
              bp_en_d = 1'b1;
            end
            OP_CLRBP: begin
              bp_d    = cmd_data[BP_W-1:0];
              bp_en_d = 1'b0;
            end
            OP_STEP: begin
              rsp_valid_d = 1'b0;
              state_d     = S_STEP;
            end
            OP_WINST, OP_RINST: begin
              rsp_valid_d = 1'b0;
              state_d     = S_ACC;
              op_d        = cmd_op;
              iaddr_d     = cmd_addr;
              if (cmd_op == OP_WINST) idata_d = cmd_data;
            end
            OP_WDATA, OP_RDATA: begin
              rsp_valid_d = 1'b0;
              state_d     = S_ACC;
              op_d        = cmd_op;
              daddr_d     = cmd_addr;
              if (cmd_op == OP_WDATA) ddata_d = cmd_data;
            end
            OP_RREG: begin
              rsp_valid_d = 1'b0;
              state_d     = S_ACC;
              op_d        = cmd_op;
              raddr_d     = cmd_addr[4:0];
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        if (cpu_stop) begin
          state_d = S_HALT;
          cause_d = C_STOP;
        end
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          case (cmd_op)
            OP_STATUS: rsp_data_d = cpu_pc;
            OP_CYCLES: rsp_data_d = cnt_q;
            OP_HALT: begin
              state_d = S_HALT;
              cause_d = C_CMD;
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
        // Breakpoint wins the cause over a coincident HALT or stop.
        if (bp_hit) begin
          state_d = S_HALT;
          cause_d = C_BP;
        end
      end
      S_STEP: begin
        rsp_valid_d = 1'b1;
        rsp_pc_d    = 1'b1;
        state_d     = S_RESP;
      end
      S_ACC: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
        case (op_q)
          OP_RINST: rsp_data_d = inst_out;
          OP_RDATA: rsp_data_d = data_out;
          OP_RREG:  rsp_data_d = rf_out;
          default:  rsp_data_d = 32'd0;
        endcase
      end
      S_RESP:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HALT;
      op_q        <= 4'd0;
      bp_q        <= '0;
      bp_en_q     <= 1'b0;
      cause_q     <= 2'd0;
      cnt_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_pc_q    <= 1'b0;
      iaddr_q     <= 8'd0;
      daddr_q     <= 8'd0;
      idata_q     <= 32'd0;
      ddata_q     <= 32'd0;
      raddr_q     <= 5'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bp_q        <= bp_d;
      bp_en_q     <= bp_en_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_pc_q    <= rsp_pc_d;
      iaddr_q     <= iaddr_d;
      daddr_q     <= daddr_d;
      idata_q     <= idata_d;
      ddata_q     <= ddata_d;
      raddr_q     <= raddr_d;
    end
  end

  // After STEP the core's PC only updates on the edge that ends
  // the step, so the response carries the live PC.
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_pc_q ? cpu_pc : rsp_data_q;
  assign inst_we    = (state_q == S_ACC) && (op_q == OP_WINST);
  assign data_we    = (state_q == S_ACC) && (op_q == OP_WDATA);
  assign rf_dcp_rd  = (state_q == S_ACC) && (op_q == OP_RREG);
  assign inst_addr  = iaddr_q;
  assign data_addr  = daddr_q;
  assign inst_in    = idata_q;
  assign data_in    = ddata_q;
  assign rf_addr    = raddr_q;
  assign halted     = (state_q != S_RUN);
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Testbench for dbg_ctrl: a small core model plus a command-level
// reference model of PC, cycle count and memory contents.
module tb_dbg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        cpu_en;
  logic [31:0] cpu_pc;
  logic        cpu_stop;
  logic        inst_we;
  logic        data_we;
  logic [7:0]  inst_addr;
  logic [7:0]  data_addr;
  logic [31:0] inst_in;
  logic [31:0] data_in;
  logic        rf_dcp_rd;
  logic [4:0]  rf_addr;
  logic [31:0] inst_out;
  logic [31:0] data_out;
  logic [31:0] rf_out;
  logic        halted;
  logic [1:0]  halt_cause;

  localparam logic [3:0] STATUS = 4'd0;
  localparam logic [3:0] RUN    = 4'd1;
  localparam logic [3:0] STEP   = 4'd2;
  localparam logic [3:0] HALT   = 4'd3;
  localparam logic [3:0] SETBP  = 4'd4;
  localparam logic [3:0] CLRBP  = 4'd5;
  localparam logic [3:0] WINST  = 4'd6;
  localparam logic [3:0] WDATA  = 4'd7;
  localparam logic [3:0] RINST  = 4'd8;
  localparam logic [3:0] RDATA  = 4'd9;
  localparam logic [3:0] RREG   = 4'd10;
  localparam logic [3:0] CYCLES = 4'd11;

  int checks = 0;
  int failures = 0;
  int iwe_seen = 0;

  // core model
  logic [31:0] pc;
  logic [31:0] stop_pc;
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] rf   [32];

  // reference model
  logic [31:0] m_pc;
  logic [31:0] m_cyc;
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  bit          m_iw [256];
  bit          m_dw [256];

  function automatic logic [31:0] rf_pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= rf_pat(i);
    end else if (cpu_en) begin
      pc <= pc + 32'd4;
    end
    if (inst_we) imem[inst_addr] <= inst_in;
    if (data_we) dmem[data_addr] <= data_in;
    if (inst_we) iwe_seen <= iwe_seen + 1;
  end

  assign cpu_pc   = pc;
  assign cpu_stop = (pc == stop_pc);
  assign inst_out = imem[inst_addr];
  assign data_out = dmem[data_addr];
  assign rf_out   = rf[rf_addr];

  dbg_ctrl #(.BP_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .cpu_en(cpu_en), .cpu_pc(cpu_pc), .cpu_stop(cpu_stop),
    .inst_we(inst_we), .data_we(data_we),
    .inst_addr(inst_addr), .data_addr(data_addr),
    .inst_in(inst_in), .data_in(data_in),
    .rf_dcp_rd(rf_dcp_rd), .rf_addr(rf_addr),
    .inst_out(inst_out), .data_out(data_out), .rf_out(rf_out),
    .halted(halted), .halt_cause(halt_cause)
  );

  // Issues one command; returns at the negedge of cycle T+1.
  task automatic send(input logic [3:0] op, input logic [7:0] a,
                      input logic [31:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL accept_timeout op=%0d ready=0 want 1", op);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    cmd_addr = 8'($urandom);
    cmd_data = $urandom;
  endtask

  task automatic wait_halted(input string tag);
    int n;
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!halted) begin
      failures++;
      $display("FAIL %s halt_timeout halted=0 want 1", tag);
    end
  endtask

  task automatic check_cycles(input string tag);
    send(CYCLES, 8'd0, 32'd0);
    checks++;
    if (!(rsp_valid && !rsp_err) || rsp_data !== m_cyc) begin
      failures++;
      $display("FAIL %s cycles got=%0d v=%0b want=%0d",
               tag, rsp_data, rsp_valid, m_cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0 || inst_we !== 1'b0 ||
        data_we !== 1'b0 || rf_dcp_rd !== 1'b0 ||
        rsp_valid !== 1'b0 || halt_cause !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs h=%b en=%b iwe=%b dwe=%b rd=%b rv=%b c=%0d want h=1 others 0",
               halted, cpu_en, inst_we, data_we, rf_dcp_rd,
               rsp_valid, halt_cause);
    end
    rst = 1'b0;
    m_pc = 32'd0;
    m_cyc = 32'd0;
    check_cycles("reset");
  endtask

  task automatic do_write(input logic [3:0] op, input logic [7:0] a,
                          input logic [31:0] d);
    logic we_ok;
    send(op, a, d);
    if (op == WDATA)
      we_ok = data_we && !inst_we && data_addr == a && data_in == d;
    else
      we_ok = inst_we && !data_we && inst_addr == a && inst_in == d;
    checks++;
    if (!we_ok || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_acc op=%0d iwe=%b dwe=%b ia=%h da=%h rv=%b want strobe addr=%h data=%h",
               op, inst_we, data_we, inst_addr, data_addr, rsp_valid, a, d);
    end
    @(negedge clk);
    checks++;
    if (inst_we || data_we || !rsp_valid || rsp_err || rsp_data !== 0) begin
      failures++;
      $display("FAIL write_rsp iwe=%b dwe=%b rv=%b err=%b d=%h want rv=1 d=0",
               inst_we, data_we, rsp_valid, rsp_err, rsp_data);
    end
    if (op == WDATA) begin
      m_dmem[a] = d;
      m_dw[a] = 1'b1;
    end else begin
      m_imem[a] = d;
      m_iw[a] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [3:0] op, input logic [7:0] a);
    logic [31:0] exp;
    send(op, a, 32'd0);
    exp = (op == RDATA) ? m_dmem[a] :
          (op == RINST) ? m_imem[a] : rf_pat(int'(a[4:0]));
    checks++;
    if (rsp_valid !== 1'b0 ||
        (op == RREG && (rf_dcp_rd !== 1'b1 || rf_addr !== a[4:0]))) begin
      failures++;
      $display("FAIL read_acc op=%0d rv=%b rd=%b ra=%0d", op, rsp_valid,
               rf_dcp_rd, rf_addr);
    end
    @(negedge clk);
    checks++;
    if (!rsp_valid || rsp_err || rsp_data !== exp || rf_dcp_rd) begin
      failures++;
      $display("FAIL read_rsp op=%0d a=%h got=%h rv=%b want=%h",
               op, a, rsp_data, rsp_valid, exp);
    end
  endtask

  task automatic test_write_read;
    do_write(WDATA, 8'h10, 32'hDEAD_BEEF);
    do_read(RDATA, 8'h10);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      do_write(i[0] ? WINST : WDATA, a, $urandom);
      do_read(i[0] ? RINST : RDATA, a);
    end
    do_read(RREG, 8'd7);
  endtask

  task automatic test_breakpoint;
    int n;
    send(SETBP, 8'd0, 32'h0000_000C);
    checks++;
    if (!rsp_valid || rsp_err || rsp_data !== 0) begin
      failures++;
      $display("FAIL setbp_rsp rv=%b d=%h want rv=1 d=0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL setbp_after rv=%b rdy=%b want rv=0 rdy=1",
               rsp_valid, cmd_ready);
    end
    send(RUN, 8'd0, 32'd0);
    checks++;
    if (!rsp_valid || rsp_data !== 0 || !cpu_en || halted) begin
      failures++;
      $display("FAIL run_ack rv=%b d=%h en=%b h=%b want 1 0 1 0",
               rsp_valid, rsp_data, cpu_en, halted);
    end
    n = 0;
    while (cpu_pc != 32'hC && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_en !== 1'b0 || halted !== 1'b0 || cpu_pc !== 32'hC) begin
      failures++;
      $display("FAIL bp_gate en=%b h=%b pc=%h want en=0 h=0 pc=c",
               cpu_en, halted, cpu_pc);
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'd2) begin
      failures++;
      $display("FAIL bp_halt h=%b c=%0d want h=1 c=2", halted, halt_cause);
    end
    m_cyc = m_cyc + (32'hC - m_pc) / 4;
    m_pc = 32'hC;
    send(STATUS, 8'd0, 32'd0);
    checks++;
    if (!rsp_valid || rsp_data !== 32'hC) begin
      failures++;
      $display("FAIL bp_status got=%h want=0000000c", rsp_data);
    end
    check_cycles("bp");
  endtask

  task automatic test_step;
    send(STEP, 8'd0, 32'd0);
    checks++;
    if (cpu_en !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL step_en en=%b rv=%b rdy=%b want 1 0 0",
               cpu_en, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cpu_en !== 1'b0 || !rsp_valid || rsp_data !== m_pc + 4) begin
      failures++;
      $display("FAIL step_rsp en=%b rv=%b d=%h want en=0 d=%h",
               cpu_en, rsp_valid, rsp_data, m_pc + 4);
    end
    @(negedge clk);
    checks++;
    if (cpu_en !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL step_done en=%b rdy=%b rv=%b want 0 1 0",
               cpu_en, cmd_ready, rsp_valid);
    end
    m_pc = m_pc + 4;
    m_cyc = m_cyc + 1;
    check_cycles("step");
  endtask

  task automatic test_reject_run;
    logic [31:0] p;
    send(SETBP, 8'd0, m_pc + 32'd400);
    send(RUN, 8'd0, 32'd0);
    iwe_seen = 0;
    send(WINST, 8'h22, 32'h1234_5678);
    checks++;
    if (!rsp_valid || !rsp_err || !cpu_en || halted) begin
      failures++;
      $display("FAIL run_reject rv=%b err=%b en=%b h=%b want 1 1 1 0",
               rsp_valid, rsp_err, cpu_en, halted);
    end
    send(STATUS, 8'd0, 32'd0);
    checks++;
    if (!rsp_valid || rsp_err || !cpu_en || rsp_data !== cpu_pc - 4) begin
      failures++;
      $display("FAIL run_status rv=%b err=%b en=%b d=%h want d=%h",
               rsp_valid, rsp_err, cpu_en, rsp_data, cpu_pc - 4);
    end
    send(HALT, 8'd0, 32'd0);
    checks++;
    if (!rsp_valid || rsp_err || cpu_en || !halted || halt_cause !== 2'd1) begin
      failures++;
      $display("FAIL halt_ack rv=%b en=%b h=%b c=%0d want 1 0 1 1",
               rsp_valid, cpu_en, halted, halt_cause);
    end
    checks++;
    if (iwe_seen != 0) begin
      failures++;
      $display("FAIL reject_iwe got=%0d want 0", iwe_seen);
    end
    send(STATUS, 8'd0, 32'd0);
    p = rsp_data;
    checks++;
    if (p <= m_pc || p >= m_pc + 400 || p[1:0] != 2'b00) begin
      failures++;
      $display("FAIL halt_pc got=%h want in (%h,%h)", p, m_pc, m_pc + 400);
    end
    m_cyc = m_cyc + (p - m_pc) / 4;
    m_pc = p;
    check_cycles("halt");
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      int sel;
      int k;
      logic [7:0] a;
      sel = int'($urandom_range(0, 4));
      k = int'($urandom_range(1, 12));
      a = 8'($urandom);
      case (sel)
        0: do_write($urandom_range(0, 1) != 0 ? WINST : WDATA, a, $urandom);
        1: begin
          if (m_dw[a]) do_read(RDATA, a);
          else if (m_iw[a]) do_read(RINST, a);
          else do_write(WDATA, a, $urandom);
        end
        2: do_read(RREG, a);
        3: begin
          send(SETBP, 8'd0, m_pc + 32'(4 * k));
          send(RUN, 8'd0, 32'd0);
          wait_halted("rnd_bp");
          m_cyc = m_cyc + 32'(k);
          m_pc = m_pc + 32'(4 * k);
          checks++;
          if (halt_cause !== 2'd2) begin
            failures++;
            $display("FAIL rnd_bp_cause got=%0d want 2", halt_cause);
          end
        end
        default: begin
          send(CLRBP, 8'd0, 32'd0);
          stop_pc = m_pc + 32'(4 * k);
          send(RUN, 8'd0, 32'd0);
          wait_halted("rnd_stop");
          m_cyc = m_cyc + 32'(k);
          m_pc = m_pc + 32'(4 * k);
          checks++;
          if (halt_cause !== 2'd3) begin
            failures++;
            $display("FAIL rnd_stop_cause got=%0d want 3", halt_cause);
          end
          stop_pc = 32'hFFFF_FFF0;
        end
      endcase
      if (sel >= 3) begin
        send(STATUS, 8'd0, 32'd0);
        checks++;
        if (rsp_data !== m_pc) begin
          failures++;
          $display("FAIL rnd_status got=%h want=%h", rsp_data, m_pc);
        end
        check_cycles("rnd");
      end
    end
  endtask

  task automatic test_reset_mid;
    send(WDATA, 8'hF0, 32'hCAFE_F00D);
    checks++;
    if (data_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_acc dwe=%b want 1", data_we);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid || data_we || !halted || halt_cause !== 2'd0 || cpu_en) begin
      failures++;
      $display("FAIL mid_reset rv=%b dwe=%b h=%b c=%0d en=%b want 0 0 1 0 0",
               rsp_valid, data_we, halted, halt_cause, cpu_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_drop rv=%b rdy=%b want rv=0 rdy=1",
               rsp_valid, cmd_ready);
    end
    m_pc = 32'd0;
    m_cyc = 32'd0;
    check_cycles("mid");
  endtask

  task automatic test_illegal;
    send(4'd14, 8'd0, 32'd0);
    checks++;
    if (!rsp_valid || !rsp_err || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL illegal_rsp rv=%b err=%b rdy=%b want 1 1 0",
               rsp_valid, rsp_err, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_after rdy=%b rv=%b want 1 0",
               cmd_ready, rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_addr = 8'd0;
    cmd_data = 32'd0;
    stop_pc = 32'hFFFF_FFF0;
    for (int i = 0; i < 256; i++) begin
      m_iw[i] = 1'b0;
      m_dw[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_breakpoint();
    test_step();
    test_reject_run();
    test_random();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
